// File: rtl/multicycle_control_fsm.sv
`default_nettype none
//============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Sequenced control unit for the 16-bit multi-cycle RISC core.
//            Runs FETCH/DECODE/EXEC/MEM/WB over a single-port memory,
//            tolerates variable memory latency through a ready handshake
//            with a bounded wait, and counts retired instructions.
// Ports    : clk, rst_n (async, active-low)
//            opcode                  - opcode field of the instruction reg
//            alu_zero_flag_in        - ALU zero flag (BEQZ condition)
//            mem_ready_in            - memory access completes this cycle
//            run_in                  - resume pulse, only honoured in HALT
//            ir_load_out, pc_write_out, pc_src_select_out
//            mem_read_enable_out, mem_write_enable_out,
//            mem_address_select_out
//            reg_write_enable_out, mem_to_reg_select_out
//            alu_opcode_out, alu_src_select_out
//            halt_cpu_out, fault_out, state_out, retired_count_out
// Revision : 1.0 - initial release
//============================================================================
module multicycle_control_fsm #(
    parameter int OPCODE_WIDTH = 4,
    parameter int WAIT_TIMEOUT = 15,
    parameter int RETIRE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    alu_zero_flag_in,
    input  logic                    mem_ready_in,
    input  logic                    run_in,
    output logic                    ir_load_out,
    output logic                    pc_write_out,
    output logic [1:0]              pc_src_select_out,
    output logic                    mem_read_enable_out,
    output logic                    mem_write_enable_out,
    output logic                    mem_address_select_out,
    output logic                    reg_write_enable_out,
    output logic                    mem_to_reg_select_out,
    output logic [3:0]              alu_opcode_out,
    output logic                    alu_src_select_out,
    output logic                    halt_cpu_out,
    output logic                    fault_out,
    output logic [2:0]              state_out,
    output logic [RETIRE_WIDTH-1:0] retired_count_out
);

    // ISA opcodes (low 4 bits of the instruction opcode field)
    localparam logic [3:0] C_OP_NOP  = 4'h0;
    localparam logic [3:0] C_OP_ADD  = 4'h1;
    localparam logic [3:0] C_OP_SUB  = 4'h2;
    localparam logic [3:0] C_OP_AND  = 4'h3;
    localparam logic [3:0] C_OP_OR   = 4'h4;
    localparam logic [3:0] C_OP_XOR  = 4'h5;
    localparam logic [3:0] C_OP_NOT  = 4'h6;
    localparam logic [3:0] C_OP_MOV  = 4'h7;
    localparam logic [3:0] C_OP_LD   = 4'h8;
    localparam logic [3:0] C_OP_ST   = 4'h9;
    localparam logic [3:0] C_OP_BEQZ = 4'hA;
    localparam logic [3:0] C_OP_JMP  = 4'hB;
    localparam logic [3:0] C_OP_HLT  = 4'hE;

    // ALU function codes
    localparam logic [3:0] C_ALU_ADD = 4'b0001;
    localparam logic [3:0] C_ALU_SUB = 4'b0010;
    localparam logic [3:0] C_ALU_AND = 4'b0011;
    localparam logic [3:0] C_ALU_OR  = 4'b0100;
    localparam logic [3:0] C_ALU_XOR = 4'b0101;
    localparam logic [3:0] C_ALU_NOT = 4'b0110;
    localparam logic [3:0] C_ALU_BYP = 4'b1111;

    // PC source and memory address selects
    localparam logic [1:0] C_PC_INC   = 2'd0;
    localparam logic [1:0] C_PC_JMP   = 2'd1;
    localparam logic [1:0] C_PC_BR    = 2'd2;
    localparam logic       C_ADDR_PC  = 1'b0;
    localparam logic       C_ADDR_ALU = 1'b1;

    // Wait counter only needs to reach WAIT_TIMEOUT
    localparam int C_WAIT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [C_WAIT_W-1:0]     C_WAIT_LIMIT = C_WAIT_W'(WAIT_TIMEOUT);
    localparam logic [C_WAIT_W-1:0]     C_WAIT_ONE   = C_WAIT_W'(1);
    localparam logic [RETIRE_WIDTH-1:0] C_RET_ONE    = RETIRE_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic [C_WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [RETIRE_WIDTH-1:0] retired_q, retired_d;

    logic       w_retire;
    logic       w_timeout;
    logic       w_op_upper_zero;
    logic       w_wait_entry;
    logic       w_in_wait;
    logic [3:0] w_op_low;

    assign w_op_low = opcode[3:0];

    // Opcodes wider than the ISA are only legal with zero upper bits
    generate
        if (OPCODE_WIDTH > 4) begin : g_op_upper
            assign w_op_upper_zero = ~|opcode[OPCODE_WIDTH-1:4];
        end else begin : g_op_no_upper
            assign w_op_upper_zero = 1'b1;
        end
    endgenerate

    // Ready in the limit cycle still wins; only a missing ready faults
    generate
        if (WAIT_TIMEOUT > 0) begin : g_timeout_en
            assign w_timeout = (wait_cnt_q == C_WAIT_LIMIT) && !mem_ready_in;
        end else begin : g_timeout_off
            assign w_timeout = 1'b0;
        end
    endgenerate

    function automatic logic f_is_rtype(input logic [3:0] op);
        return (op == C_OP_ADD) || (op == C_OP_SUB) || (op == C_OP_AND) ||
               (op == C_OP_OR)  || (op == C_OP_XOR) || (op == C_OP_NOT);
    endfunction

    function automatic logic [3:0] f_rtype_alu(input logic [3:0] op);
        logic [3:0] alu;
        case (op)
            C_OP_ADD: alu = C_ALU_ADD;
            C_OP_SUB: alu = C_ALU_SUB;
            C_OP_AND: alu = C_ALU_AND;
            C_OP_OR:  alu = C_ALU_OR;
            C_OP_XOR: alu = C_ALU_XOR;
            C_OP_NOT: alu = C_ALU_NOT;
            default:  alu = C_ALU_BYP;
        endcase
        return alu;
    endfunction

    //------------------------------------------------------------------------
    // Next-state and control decode
    //------------------------------------------------------------------------
    always_comb begin
        state_d                = state_q;
        op_d                   = op_q;
        w_retire               = 1'b0;
        ir_load_out            = 1'b0;
        pc_write_out           = 1'b0;
        pc_src_select_out      = C_PC_INC;
        mem_read_enable_out    = 1'b0;
        mem_write_enable_out   = 1'b0;
        mem_address_select_out = C_ADDR_PC;
        reg_write_enable_out   = 1'b0;
        mem_to_reg_select_out  = 1'b0;
        alu_opcode_out         = C_ALU_BYP;
        alu_src_select_out     = 1'b0;
        halt_cpu_out           = 1'b0;
        fault_out              = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_read_enable_out    = 1'b1;
                mem_address_select_out = C_ADDR_PC;
                if (mem_ready_in) begin
                    ir_load_out       = 1'b1;
                    pc_write_out      = 1'b1;
                    pc_src_select_out = C_PC_INC;
                    state_d           = S_DECODE;
                end else if (w_timeout) begin
                    state_d = S_FAULT;
                end
            end

            S_DECODE: begin
                op_d = w_op_low;
                if (!w_op_upper_zero) begin
                    state_d = S_FAULT;
                end else begin
                    case (w_op_low)
                        C_OP_NOP: begin
                            state_d  = S_FETCH;
                            w_retire = 1'b1;
                        end
                        C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR, C_OP_XOR,
                        C_OP_NOT, C_OP_MOV, C_OP_LD, C_OP_ST, C_OP_BEQZ,
                        C_OP_JMP: begin
                            state_d = S_EXEC;
                        end
                        C_OP_HLT: begin
                            state_d  = S_HALT;
                            w_retire = 1'b1;
                        end
                        default: begin
                            state_d = S_FAULT;
                        end
                    endcase
                end
            end

            S_EXEC: begin
                if (f_is_rtype(op_q)) begin
                    alu_opcode_out     = f_rtype_alu(op_q);
                    alu_src_select_out = 1'b0;
                    state_d            = S_WB;
                end else begin
                    case (op_q)
                        C_OP_MOV: begin
                            alu_opcode_out     = C_ALU_ADD;
                            alu_src_select_out = 1'b1;
                            state_d            = S_WB;
                        end
                        C_OP_LD, C_OP_ST: begin
                            alu_opcode_out         = C_ALU_ADD;
                            alu_src_select_out     = 1'b0;
                            mem_address_select_out = C_ADDR_ALU;
                            state_d                = S_MEM;
                        end
                        C_OP_BEQZ: begin
                            alu_opcode_out     = C_ALU_BYP;
                            alu_src_select_out = 1'b1;
                            if (alu_zero_flag_in) begin
                                pc_write_out      = 1'b1;
                                pc_src_select_out = C_PC_BR;
                            end
                            state_d  = S_FETCH;
                            w_retire = 1'b1;
                        end
                        C_OP_JMP: begin
                            pc_write_out      = 1'b1;
                            pc_src_select_out = C_PC_JMP;
                            state_d           = S_FETCH;
                            w_retire          = 1'b1;
                        end
                        default: begin
                            // Only decoded opcodes reach EXEC; anything else is corruption
                            state_d = S_FAULT;
                        end
                    endcase
                end
            end

            S_MEM: begin
                // Address path held stable for the whole access
                alu_opcode_out         = C_ALU_ADD;
                mem_address_select_out = C_ADDR_ALU;
                case (op_q)
                    C_OP_LD: begin
                        mem_read_enable_out = 1'b1;
                        if (mem_ready_in) begin
                            state_d = S_WB;
                        end else if (w_timeout) begin
                            state_d = S_FAULT;
                        end
                    end
                    C_OP_ST: begin
                        mem_write_enable_out = 1'b1;
                        if (mem_ready_in) begin
                            state_d  = S_FETCH;
                            w_retire = 1'b1;
                        end else if (w_timeout) begin
                            state_d = S_FAULT;
                        end
                    end
                    default: begin
                        state_d = S_FAULT;
                    end
                endcase
            end

            S_WB: begin
                reg_write_enable_out  = 1'b1;
                mem_to_reg_select_out = (op_q == C_OP_LD);
                // Keep the ALU result stable while it is written back
                if (f_is_rtype(op_q)) begin
                    alu_opcode_out     = f_rtype_alu(op_q);
                    alu_src_select_out = 1'b0;
                end else if (op_q == C_OP_MOV) begin
                    alu_opcode_out     = C_ALU_ADD;
                    alu_src_select_out = 1'b1;
                end
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end

            S_HALT: begin
                halt_cpu_out = 1'b1;
                if (run_in) begin
                    state_d = S_FETCH;
                end
            end

            S_FAULT: begin
                halt_cpu_out = 1'b1;
                fault_out    = 1'b1;
            end

            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Wait and retire counters
    //------------------------------------------------------------------------
    assign w_in_wait = (state_q == S_FETCH) || (state_q == S_MEM);

    always_comb begin
        w_wait_entry = ((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q);
        wait_cnt_d   = wait_cnt_q;
        if (w_wait_entry) begin
            wait_cnt_d = '0;
        end else if (w_in_wait && !mem_ready_in && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + C_WAIT_ONE;
        end

        retired_d = retired_q;
        if (w_retire && (retired_q != '1)) begin
            retired_d = retired_q + C_RET_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= 4'h0;
            wait_cnt_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
        end
    end

    assign state_out         = state_q;
    assign retired_count_out = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
//============================================================================
// Module   : tb_multicycle_control_fsm
// Purpose  : Self-checking bench for multicycle_control_fsm. Each scenario
//            plans per-cycle stimulus with expected control vectors; the
//            expectation is queued as the stimulus is driven and popped
//            when the cycle's outputs are sampled on the falling edge.
//            A second instance with a 2-bit retire counter shares inputs.
// Revision : 1.0 - initial release
//============================================================================
module tb_multicycle_control_fsm;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2, ST_EXEC = 3'd3;
    localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6, ST_FAULT = 3'd7;
    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_MOV = 4'h7, OP_LD = 4'h8;
    localparam logic [3:0] OP_ST = 4'h9, OP_BEQZ = 4'hA, OP_JMP = 4'hB, OP_HLT = 4'hE;
    localparam logic [3:0] OP_BAD = 4'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        alu_zero_flag_in = 1'b0;
    logic        mem_ready_in = 1'b0;
    logic        run_in = 1'b0;

    logic        ir_load_out, pc_write_out, mem_read_enable_out, mem_write_enable_out;
    logic        mem_address_select_out, reg_write_enable_out, mem_to_reg_select_out;
    logic        alu_src_select_out, halt_cpu_out, fault_out;
    logic [1:0]  pc_src_select_out;
    logic [3:0]  alu_opcode_out;
    logic [2:0]  state_out;
    logic [15:0] retired_count_out;

    logic        d2_ir, d2_pcw, d2_rd, d2_wr, d2_as, d2_rw, d2_m2r, d2_src, d2_halt, d2_fault;
    logic [1:0]  d2_pcs;
    logic [3:0]  d2_alu;
    logic [2:0]  d2_state;
    logic [1:0]  d2_retired;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.OPCODE_WIDTH(4), .WAIT_TIMEOUT(15), .RETIRE_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero_flag_in(alu_zero_flag_in),
        .mem_ready_in(mem_ready_in), .run_in(run_in),
        .ir_load_out(ir_load_out), .pc_write_out(pc_write_out),
        .pc_src_select_out(pc_src_select_out), .mem_read_enable_out(mem_read_enable_out),
        .mem_write_enable_out(mem_write_enable_out),
        .mem_address_select_out(mem_address_select_out),
        .reg_write_enable_out(reg_write_enable_out),
        .mem_to_reg_select_out(mem_to_reg_select_out), .alu_opcode_out(alu_opcode_out),
        .alu_src_select_out(alu_src_select_out), .halt_cpu_out(halt_cpu_out),
        .fault_out(fault_out), .state_out(state_out), .retired_count_out(retired_count_out)
    );

    multicycle_control_fsm #(.OPCODE_WIDTH(4), .WAIT_TIMEOUT(15), .RETIRE_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero_flag_in(alu_zero_flag_in),
        .mem_ready_in(mem_ready_in), .run_in(run_in),
        .ir_load_out(d2_ir), .pc_write_out(d2_pcw), .pc_src_select_out(d2_pcs),
        .mem_read_enable_out(d2_rd), .mem_write_enable_out(d2_wr),
        .mem_address_select_out(d2_as), .reg_write_enable_out(d2_rw),
        .mem_to_reg_select_out(d2_m2r), .alu_opcode_out(d2_alu),
        .alu_src_select_out(d2_src), .halt_cpu_out(d2_halt), .fault_out(d2_fault),
        .state_out(d2_state), .retired_count_out(d2_retired)
    );

    wire [18:0] obs = {ir_load_out, pc_write_out, pc_src_select_out, mem_read_enable_out,
                       mem_write_enable_out, mem_address_select_out, reg_write_enable_out,
                       mem_to_reg_select_out, alu_opcode_out, alu_src_select_out,
                       halt_cpu_out, fault_out, state_out};

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        zero;
        logic [3:0]  op;
        logic        run;
        logic [18:0] v;
        logic [15:0] ret;
        logic [1:0]  ret2;
    } step_t;

    step_t plan[$];
    step_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;

    logic [18:0] v_idle, v_frdy, v_fwait, v_dec, v_halt, v_fault;

    function automatic logic [18:0] mk(input logic [2:0] st, input logic ir, pcw,
                                       input logic [1:0] pcs, input logic rd, wr, as, rw, m2r,
                                       input logic [3:0] alu, input logic src, halt, flt);
        return {ir, pcw, pcs, rd, wr, as, rw, m2r, alu, src, halt, flt, st};
    endfunction

    function automatic void add(input logic rst, rdy, zero, input logic [3:0] op,
                                input logic run, input logic [18:0] v, input int ret);
        step_t s;
        s.rst  = rst;
        s.rdy  = rdy;
        s.zero = zero;
        s.op   = op;
        s.run  = run;
        s.v    = v;
        s.ret  = 16'(ret);
        s.ret2 = (ret > 3) ? 2'd3 : 2'(ret);
        plan.push_back(s);
    endfunction

    // Assert reset for one cycle, then release; both cycles sit in IDLE
    function automatic void add_reset();
        add(1, 0, 0, OP_NOP, 0, v_idle, 0);
        add(0, 0, 0, OP_NOP, 0, v_idle, 0);
    endfunction

    task automatic drive(input step_t s);
        @(posedge clk);
        #1;
        rst_n            = !s.rst;
        mem_ready_in     = s.rdy;
        alu_zero_flag_in = s.zero;
        opcode           = s.op;
        run_in           = s.run;
    endtask

    task automatic test_reset();
        step_t e;
        add_reset();
        add(0, 1, 0, OP_ST, 0, v_frdy, 0);
        add(0, 1, 0, OP_ST, 0, v_dec, 0);
        add(0, 1, 0, OP_ST, 0, mk(ST_EXEC,0,0,0,0,0,1,0,0,4'h1,0,0,0), 0);
        add(0, 0, 0, OP_ST, 0, mk(ST_MEM,0,0,0,0,1,1,0,0,4'h1,0,0,0), 0);
        add_reset();
        add(0, 0, 0, OP_NOP, 0, v_fwait, 0);
        foreach (plan[i]) begin
            drive(plan[i]);
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v || retired_count_out !== e.ret || d2_retired !== e.ret2) begin
                n_errors++;
                $display("FAIL reset[%0d]: got ctl=%h ret=%0d ret2=%0d want ctl=%h ret=%0d ret2=%0d",
                         i, obs, retired_count_out, d2_retired, e.v, e.ret, e.ret2);
            end
        end
        plan.delete();
    endtask

    task automatic test_add();
        step_t e;
        add_reset();
        add(0, 1, 0, OP_ADD, 0, v_frdy, 0);
        add(0, 1, 0, OP_ADD, 0, v_dec, 0);
        // Opcode changes after DECODE must not disturb the instruction
        add(0, 1, 0, OP_BAD, 0, mk(ST_EXEC,0,0,0,0,0,0,0,0,4'h1,0,0,0), 0);
        add(0, 1, 0, OP_BAD, 0, mk(ST_WB,0,0,0,0,0,0,1,0,4'h1,0,0,0), 0);
        add(0, 0, 0, OP_BAD, 0, v_fwait, 1);
        foreach (plan[i]) begin
            drive(plan[i]);
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v || retired_count_out !== e.ret || d2_retired !== e.ret2) begin
                n_errors++;
                $display("FAIL add[%0d]: got ctl=%h ret=%0d ret2=%0d want ctl=%h ret=%0d ret2=%0d",
                         i, obs, retired_count_out, d2_retired, e.v, e.ret, e.ret2);
            end
        end
        plan.delete();
    endtask

    task automatic test_ld_wait();
        step_t e;
        add_reset();
        add(0, 1, 0, OP_LD, 0, v_frdy, 0);
        add(0, 1, 0, OP_LD, 0, v_dec, 0);
        add(0, 1, 0, OP_LD, 0, mk(ST_EXEC,0,0,0,0,0,1,0,0,4'h1,0,0,0), 0);
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, OP_LD, 0, mk(ST_MEM,0,0,0,1,0,1,0,0,4'h1,0,0,0), 0);
        add(0, 1, 0, OP_LD, 0, mk(ST_MEM,0,0,0,1,0,1,0,0,4'h1,0,0,0), 0);
        add(0, 1, 0, OP_LD, 0, mk(ST_WB,0,0,0,0,0,0,1,1,4'hF,0,0,0), 0);
        add(0, 0, 0, OP_LD, 0, v_fwait, 1);
        foreach (plan[i]) begin
            drive(plan[i]);
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v || retired_count_out !== e.ret || d2_retired !== e.ret2) begin
                n_errors++;
                $display("FAIL ld_wait[%0d]: got ctl=%h ret=%0d ret2=%0d want ctl=%h ret=%0d ret2=%0d",
                         i, obs, retired_count_out, d2_retired, e.v, e.ret, e.ret2);
            end
        end
        plan.delete();
    endtask

    task automatic test_beqz();
        step_t e;
        add_reset();
        add(0, 1, 1, OP_BEQZ, 0, v_frdy, 0);
        add(0, 1, 1, OP_BEQZ, 0, v_dec, 0);
        add(0, 1, 1, OP_BEQZ, 0, mk(ST_EXEC,0,1,2'd2,0,0,0,0,0,4'hF,1,0,0), 0);
        add(0, 1, 0, OP_BEQZ, 0, v_frdy, 1);
        add(0, 1, 0, OP_BEQZ, 0, v_dec, 1);
        add(0, 1, 0, OP_BEQZ, 0, mk(ST_EXEC,0,0,2'd0,0,0,0,0,0,4'hF,1,0,0), 1);
        add(0, 0, 0, OP_BEQZ, 0, v_fwait, 2);
        foreach (plan[i]) begin
            drive(plan[i]);
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v || retired_count_out !== e.ret || d2_retired !== e.ret2) begin
                n_errors++;
                $display("FAIL beqz[%0d]: got ctl=%h ret=%0d ret2=%0d want ctl=%h ret=%0d ret2=%0d",
                         i, obs, retired_count_out, d2_retired, e.v, e.ret, e.ret2);
            end
        end
        plan.delete();
    endtask

    task automatic test_timeout();
        step_t e;
        add_reset();
        for (int k = 0; k < 16; k++) add(0, 0, 0, OP_NOP, 0, v_fwait, 0);
        add(0, 0, 0, OP_NOP, 0, v_fault, 0);
        add_reset();
        // Ready arrives in the limit cycle: the fetch completes normally
        for (int k = 0; k < 15; k++) add(0, 0, 0, OP_NOP, 0, v_fwait, 0);
        add(0, 1, 0, OP_NOP, 0, v_frdy, 0);
        add(0, 1, 0, OP_NOP, 0, v_dec, 0);
        add(0, 0, 0, OP_NOP, 0, v_fwait, 1);
        foreach (plan[i]) begin
            drive(plan[i]);
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v || retired_count_out !== e.ret || d2_retired !== e.ret2) begin
                n_errors++;
                $display("FAIL timeout[%0d]: got ctl=%h ret=%0d ret2=%0d want ctl=%h ret=%0d ret2=%0d",
                         i, obs, retired_count_out, d2_retired, e.v, e.ret, e.ret2);
            end
        end
        plan.delete();
    endtask

    task automatic test_halt_fault();
        step_t e;
        add_reset();
        add(0, 0, 0, OP_HLT, 1, v_fwait, 0);
        add(0, 1, 0, OP_HLT, 0, v_frdy, 0);
        add(0, 1, 0, OP_HLT, 0, v_dec, 0);
        for (int k = 0; k < 5; k++) add(0, 1, 0, OP_HLT, 0, v_halt, 1);
        add(0, 1, 0, OP_HLT, 1, v_halt, 1);
        add(0, 1, 0, OP_BAD, 0, v_frdy, 1);
        add(0, 1, 0, OP_BAD, 0, v_dec, 1);
        add(0, 1, 0, OP_BAD, 1, v_fault, 1);
        add(0, 1, 0, OP_BAD, 1, v_fault, 1);
        add_reset();
        add(0, 0, 0, OP_NOP, 0, v_fwait, 0);
        foreach (plan[i]) begin
            drive(plan[i]);
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v || retired_count_out !== e.ret || d2_retired !== e.ret2) begin
                n_errors++;
                $display("FAIL halt_fault[%0d]: got ctl=%h ret=%0d ret2=%0d want ctl=%h ret=%0d ret2=%0d",
                         i, obs, retired_count_out, d2_retired, e.v, e.ret, e.ret2);
            end
        end
        plan.delete();
    endtask

    task automatic test_retire_sat();
        step_t e;
        add_reset();
        for (int k = 0; k < 5; k++) begin
            add(0, 1, 0, OP_NOP, 0, v_frdy, k);
            add(0, 1, 0, OP_NOP, 0, v_dec, k);
        end
        add(0, 0, 0, OP_NOP, 0, v_fwait, 5);
        foreach (plan[i]) begin
            drive(plan[i]);
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v || retired_count_out !== e.ret || d2_retired !== e.ret2) begin
                n_errors++;
                $display("FAIL retire_sat[%0d]: got ctl=%h ret=%0d ret2=%0d want ctl=%h ret=%0d ret2=%0d",
                         i, obs, retired_count_out, d2_retired, e.v, e.ret, e.ret2);
            end
        end
        plan.delete();
    endtask

    task automatic test_back_to_back();
        step_t e;
        logic [3:0] r_ops  [5] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        logic [3:0] r_alus [5] = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110};
        add_reset();
        add(0, 1, 0, OP_JMP, 0, v_frdy, 0);
        add(0, 1, 0, OP_JMP, 0, v_dec, 0);
        add(0, 1, 0, OP_JMP, 0, mk(ST_EXEC,0,1,2'd1,0,0,0,0,0,4'hF,0,0,0), 0);
        add(0, 1, 0, OP_ST, 0, v_frdy, 1);
        add(0, 1, 0, OP_ST, 0, v_dec, 1);
        add(0, 1, 0, OP_ST, 0, mk(ST_EXEC,0,0,0,0,0,1,0,0,4'h1,0,0,0), 1);
        add(0, 1, 0, OP_ST, 0, mk(ST_MEM,0,0,0,0,1,1,0,0,4'h1,0,0,0), 1);
        add(0, 1, 0, OP_MOV, 0, v_frdy, 2);
        add(0, 1, 0, OP_MOV, 0, v_dec, 2);
        add(0, 1, 0, OP_MOV, 0, mk(ST_EXEC,0,0,0,0,0,0,0,0,4'h1,1,0,0), 2);
        add(0, 1, 0, OP_MOV, 0, mk(ST_WB,0,0,0,0,0,0,1,0,4'h1,1,0,0), 2);
        for (int k = 0; k < 5; k++) begin
            add(0, 1, 0, r_ops[k], 0, v_frdy, 3 + k);
            add(0, 1, 0, r_ops[k], 0, v_dec, 3 + k);
            add(0, 1, 0, r_ops[k], 0, mk(ST_EXEC,0,0,0,0,0,0,0,0,r_alus[k],0,0,0), 3 + k);
            add(0, 1, 0, r_ops[k], 0, mk(ST_WB,0,0,0,0,0,0,1,0,r_alus[k],0,0,0), 3 + k);
        end
        add(0, 0, 0, OP_NOP, 0, v_fwait, 8);
        foreach (plan[i]) begin
            drive(plan[i]);
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v || retired_count_out !== e.ret || d2_retired !== e.ret2) begin
                n_errors++;
                $display("FAIL back_to_back[%0d]: got ctl=%h ret=%0d ret2=%0d want ctl=%h ret=%0d ret2=%0d",
                         i, obs, retired_count_out, d2_retired, e.v, e.ret, e.ret2);
            end
        end
        plan.delete();
    endtask

    initial begin
        v_idle  = mk(ST_IDLE, 0,0,0,0,0,0,0,0,4'hF,0,0,0);
        v_frdy  = mk(ST_FETCH,1,1,0,1,0,0,0,0,4'hF,0,0,0);
        v_fwait = mk(ST_FETCH,0,0,0,1,0,0,0,0,4'hF,0,0,0);
        v_dec   = mk(ST_DEC,  0,0,0,0,0,0,0,0,4'hF,0,0,0);
        v_halt  = mk(ST_HALT, 0,0,0,0,0,0,0,0,4'hF,0,1,0);
        v_fault = mk(ST_FAULT,0,0,0,0,0,0,0,0,4'hF,0,1,1);

        test_reset();
        test_add();
        test_ld_wait();
        test_beqz();
        test_timeout();
        test_halt_fault();
        test_retire_sat();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Sequenced control unit for the 16-bit multi-cycle von Neumann RISC. It replaces purely combinational decode with a registered FSM that runs FETCH/DECODE/EXEC/MEM/WB over the single-port memory. It handles variable memory latency through a ready handshake with a configurable timeout, and counts retired instructions. It sits between the instruction register and the datapath, and drives every datapath control wire.

## Interface
- OPCODE_WIDTH, 4: instruction opcode width; the ISA encodings occupy the low 4 bits.
- WAIT_TIMEOUT, 15: maximum memory wait cycles before FAULT; 0 disables the timeout.
- RETIRE_WIDTH, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  OPCODE_WIDTH  opcode field of the instruction register.
- alu_zero_flag_in  in  1  ALU zero flag.
- mem_ready_in  in  1  memory completion handshake.
- run_in  in  1  resume pulse; leaves HALT.
- ir_load_out  out  1  load instruction register.
- pc_write_out  out  1  update PC.
- pc_src_select_out  out  2  PC source: 0 = PC+1, 1 = jump imm9, 2 = branch target.
- mem_read_enable_out  out  1  memory read request.
- mem_write_enable_out  out  1  memory write request.
- mem_address_select_out  out  1  memory address: 0 = PC, 1 = ALU.
- reg_write_enable_out  out  1  register-file write.
- mem_to_reg_select_out  out  1  write-back source: 0 = ALU, 1 = memory.
- alu_opcode_out  out  4  ALU opcode: ADD 0001, SUB 0010, AND 0011, OR 0100, XOR 0101, NOT 0110, BYP 1111.
- alu_src_select_out  out  1  ALU operand 2: 0 = register data2, 1 = immediate.
- halt_cpu_out  out  1  core halted.
- fault_out  out  1  illegal opcode or memory timeout.
- state_out  out  3  current state encoding.
- retired_count_out  out  RETIRE_WIDTH  retired instructions; saturates at all-ones.

## Operation
- State encodings: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 6, FAULT 7.
- Outputs are a decode of the state and the latched opcode op_q. Any output not listed for a state is 0; alu_opcode_out defaults to 1111.
- IDLE: no controls asserted; moves to FETCH unconditionally.
- FETCH:
  - mem_read_enable_out=1, mem_address_select_out=0.
  - On mem_ready_in=1 in the same cycle: ir_load_out=1, pc_write_out=1, pc_src_select_out=0, and the FSM moves to DECODE.
- DECODE:
  - op_q is loaded from opcode; op_q is used for the rest of the instruction.
  - NOP moves to FETCH and retires.
  - ADD/SUB/AND/OR/XOR/NOT/MOV/LD/ST/BEQZ/JMP move to EXEC.
  - HLT moves to HALT and retires.
  - Any other opcode moves to FAULT.
- EXEC:
  - R-type: ALU opcode per instruction, alu_src_select_out=0; moves to WB.
  - MOV: ALU ADD, alu_src_select_out=1; moves to WB.
  - LD/ST: ALU ADD, alu_src_select_out=0, mem_address_select_out=1; moves to MEM.
  - BEQZ: ALU BYP, alu_src_select_out=1. If alu_zero_flag_in=1: pc_write_out=1, pc_src_select_out=2. Moves to FETCH and retires.
  - JMP: pc_write_out=1, pc_src_select_out=1; moves to FETCH and retires.
- MEM:
  - ALU ADD and mem_address_select_out=1 are held throughout.
  - LD: mem_read_enable_out=1; moves to WB on ready.
  - ST: mem_write_enable_out=1; moves to FETCH on ready and retires.
- WB: reg_write_enable_out=1 for exactly one cycle, with mem_to_reg_select_out=1 for LD and 0 otherwise. The ALU controls of EXEC are held (R-type and MOV). Moves to FETCH and retires.
- HALT: halt_cpu_out=1; run_in=1 moves to FETCH.
- FAULT: halt_cpu_out=1 and fault_out=1; only rst_n exits this state.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle that mem_ready_in=0.
  - If the counter equals WAIT_TIMEOUT (nonzero) and mem_ready_in=0, the FSM moves to FAULT.
  - mem_ready_in=1 in that same cycle takes priority and completes the access normally.
- Retire counter: +1 per retiring transition; holds at 2^RETIRE_WIDTH-1.

## Timing
- Reset (asynchronous assert): state=IDLE, op_q=0, both counters 0. All outputs are 0 except alu_opcode_out=1111 and state_out=0.
- Reset release: the first rising edge moves to FETCH.
- Latency with zero-wait memory (mem_ready_in tied 1), counted in cycles from FETCH entry to the next FETCH:
  - NOP: 2.
  - JMP/BEQZ: 3.
  - ST: 4.
  - R-type and MOV: 4.
  - LD: 5.
- Each wait cycle adds 1.
- Memory requests stay asserted and stable until the cycle in which mem_ready_in=1 is sampled; they drop on the next edge.
- A reset asserted mid-access aborts the access immediately; no partial write is guaranteed.
- A change on opcode after DECODE has no effect.
- run_in outside HALT is ignored.

## Test plan
- Reset, mem_ready_in=1, instruction ADD (0001) -> states 0,1,2,3,5,1. In the WB cycle: reg_write_enable_out=1, alu_opcode_out=0001. retired_count_out=1.
- LD (1000) with mem_ready_in low for 3 cycles in MEM -> MEM lasts 4 cycles with mem_read_enable_out=1 and mem_address_select_out=1. Then WB with mem_to_reg_select_out=1.
- BEQZ (1010), with zero flag 1 then 0 on a second run -> pc_write_out=1 with pc_src_select_out=2 only in the zero=1 run. Both runs return to FETCH after 3 cycles.
- FETCH with mem_ready_in=0 held for 16 cycles, WAIT_TIMEOUT=15 -> FAULT entered; fault_out=1 and halt_cpu_out=1. A retry with ready arriving on wait cycle 15 completes with no fault.
- HLT (1110), then run_in pulse after 5 cycles -> halt_cpu_out=1 for those cycles, count +1, then FETCH. Opcode 1100 -> FAULT; it persists with run_in=1 and clears only on rst_n=0.
- Retire saturation: RETIRE_WIDTH=2 with 5 NOPs -> retired_count_out steps 1, 2, 3, 3, 3.
